// File: rtl/seg7_pkg.sv
// Shared constants for the 4-digit seven-segment scan controller.
// Segment patterns are {g,f,e,d,c,b,a}, active low.
package seg7_pkg;

   localparam int unsigned NUM_DIGITS = 4;
   localparam int unsigned NIB_W      = 4;
   localparam int unsigned SEG_W      = 7;
   localparam int unsigned IDX_W      = 2;
   localparam int unsigned DATA_W     = NUM_DIGITS * NIB_W;

   localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
   localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
   localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
   localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
   localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
   localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
   localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
   localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
   localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
   localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Host-side load bus and display-side drive signals of the scan controller.
//   master : host/bench side (drives load, data_in, dp_in, blank_lz)
//   slave  : controller side (drives seg_n, dp_n, an_n, frame_done)
interface seg7_scan_ctrl_if;
   import seg7_pkg::*;

   logic                  load;
   logic [DATA_W-1:0]     data_in;
   logic [NUM_DIGITS-1:0] dp_in;
   logic                  blank_lz;
   logic [SEG_W-1:0]      seg_n;
   logic                  dp_n;
   logic [NUM_DIGITS-1:0] an_n;
   logic                  frame_done;

   modport master (
      output load, data_in, dp_in, blank_lz,
      input  seg_n, dp_n, an_n, frame_done
   );

   modport slave (
      input  load, data_in, dp_in, blank_lz,
      output seg_n, dp_n, an_n, frame_done
   );

endinterface

// File: rtl/bcd_seg7_dec.sv
// Combinational BCD to seven-segment decoder, active-low segments.
//   bcd   : 4-bit digit value
//   seg_n : {g,f,e,d,c,b,a}; non-decimal codes 10..15 give all segments off
module bcd_seg7_dec
   import seg7_pkg::*;
(
   input  logic [NIB_W-1:0] bcd,
   output logic [SEG_W-1:0] seg_n
);

   always_comb begin
      seg_n = SEG_BLANK;
      case (bcd)
         4'd0:    seg_n = SEG_0;
         4'd1:    seg_n = SEG_1;
         4'd2:    seg_n = SEG_2;
         4'd3:    seg_n = SEG_3;
         4'd4:    seg_n = SEG_4;
         4'd5:    seg_n = SEG_5;
         4'd6:    seg_n = SEG_6;
         4'd7:    seg_n = SEG_7;
         4'd8:    seg_n = SEG_8;
         4'd9:    seg_n = SEG_9;
         default: seg_n = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 4-digit seven-segment scan controller.
//   clk, rst : system clock, asynchronous active-high reset
//   bus      : slave side of seg7_scan_ctrl_if
//              (load/data_in/dp_in/blank_lz in; seg_n/dp_n/an_n/frame_done out)
// Parameters: CLK_DIV clocks per digit slot (>= 4), DEAD_CYC blanking clocks
// at the start of each slot (< CLK_DIV).
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int unsigned CLK_DIV  = 50000,
   parameter int unsigned DEAD_CYC = 2
) (
   input  logic               clk,
   input  logic               rst,
   seg7_scan_ctrl_if.slave    bus
);

   localparam int unsigned CNT_W = $clog2(CLK_DIV);

   logic [CNT_W-1:0]      cnt;
   logic [IDX_W-1:0]      idx;
   logic                  tick;
   logic                  frame_end;

   logic [DATA_W-1:0]     act_data;
   logic [NUM_DIGITS-1:0] act_dp;
   logic [DATA_W-1:0]     pend_data;
   logic [NUM_DIGITS-1:0] pend_dp;
   logic                  pend_valid;

   logic [NIB_W-1:0]      cur_nib;
   logic [SEG_W-1:0]      dec_seg;
   logic [NUM_DIGITS-1:0] lz_blank;
   logic                  zero_above;
   logic                  dead;

   logic [SEG_W-1:0]      seg_q;
   logic                  dp_q;
   logic [NUM_DIGITS-1:0] an_q;
   logic                  fd_q;

   assign tick      = (cnt == CNT_W'(CLK_DIV - 1));
   assign frame_end = tick && (idx == IDX_W'(NUM_DIGITS - 1));
   assign dead      = (cnt < CNT_W'(DEAD_CYC));
   assign cur_nib   = act_data[{idx, 2'b00} +: NIB_W];

   // Slot prescaler and digit index
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         idx <= '0;
      end else if (tick) begin
         cnt <= '0;
         idx <= idx + IDX_W'(1);
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // Double-buffered display data; active only changes at a frame boundary.
   // A load coinciding with the boundary goes straight to active so it is
   // neither delayed a frame nor later overwritten by stale pending data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         act_data   <= '0;
         act_dp     <= '0;
         pend_data  <= '0;
         pend_dp    <= '0;
         pend_valid <= 1'b0;
      end else if (frame_end) begin
         pend_valid <= 1'b0;
         if (bus.load) begin
            act_data <= bus.data_in;
            act_dp   <= bus.dp_in;
         end else if (pend_valid) begin
            act_data <= pend_data;
            act_dp   <= pend_dp;
         end
      end else if (bus.load) begin
         pend_data  <= bus.data_in;
         pend_dp    <= bus.dp_in;
         pend_valid <= 1'b1;
      end
   end

   // Leading-zero mask: digit i blanks when it and all higher digits are zero
   always_comb begin
      lz_blank   = '0;
      zero_above = 1'b1;
      for (int i = int'(NUM_DIGITS) - 1; i > 0; i--) begin
         zero_above  = zero_above & (act_data[i*NIB_W +: NIB_W] == 4'd0);
         lz_blank[i] = bus.blank_lz & zero_above;
      end
   end

   bcd_seg7_dec u_dec (
      .bcd   (cur_nib),
      .seg_n (dec_seg)
   );

   // Registered display drive; everything dark during the dead time
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg_q <= SEG_BLANK;
         dp_q  <= 1'b1;
         an_q  <= '1;
         fd_q  <= 1'b0;
      end else begin
         fd_q <= frame_end;
         if (dead) begin
            seg_q <= SEG_BLANK;
            dp_q  <= 1'b1;
            an_q  <= '1;
         end else begin
            seg_q <= lz_blank[idx] ? SEG_BLANK : dec_seg;
            dp_q  <= ~act_dp[idx];
            an_q  <= ~(NUM_DIGITS'(1) << idx);
         end
      end
   end

   assign bus.seg_n      = seg_q;
   assign bus.dp_n       = dp_q;
   assign bus.an_n       = an_q;
   assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed self-checking bench for seg7_scan_ctrl with CLK_DIV=4, DEAD_CYC=1.
module tb_seg7_scan_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   seg7_scan_ctrl_if bus ();

   seg7_scan_ctrl #(.CLK_DIV(4), .DEAD_CYC(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Runs nsteps clocks from a frame start. Sample j reflects slot state j:
   // digit j/4, dead when j%4==0. exp_seg packs {d3,d2,d1,d0}, 7 bits each.
   // Up to two loads are driven so they are captured at the clock of state la/lb.
   task automatic run_frame(input string tag, input logic [27:0] exp_seg,
                            input logic [3:0] exp_dpn,
                            input int la, input logic [15:0] da, input logic [3:0] pa,
                            input int lb, input logic [15:0] db, input logic [3:0] pb,
                            input int nsteps);
      logic [3:0] an_exp;
      int d;
      for (int j = 0; j < nsteps; j++) begin
         d = j / 4;
         bus.load    = (j == la) || (j == lb);
         bus.data_in = (j == lb) ? db : da;
         bus.dp_in   = (j == lb) ? pb : pa;
         @(posedge clk);
         @(negedge clk);
         bus.load = 1'b0;
         case (d)
            0:       an_exp = 4'b1110;
            1:       an_exp = 4'b1101;
            2:       an_exp = 4'b1011;
            default: an_exp = 4'b0111;
         endcase
         if (j % 4 == 0)
            chk($sformatf("%s d%0d dead an", tag, d), 16'(bus.an_n), 16'hF);
         if (j % 4 == 2) begin
            chk($sformatf("%s d%0d an", tag, d), 16'(bus.an_n), 16'(an_exp));
            chk($sformatf("%s d%0d seg", tag, d), 16'(bus.seg_n), 16'(exp_seg[d*7 +: 7]));
            chk($sformatf("%s d%0d dp", tag, d), 16'(bus.dp_n), 16'(exp_dpn[d]));
         end
         if (j == 7)
            chk($sformatf("%s mid fd", tag), 16'(bus.frame_done), 16'h0);
         if (j == 15)
            chk($sformatf("%s end fd", tag), 16'(bus.frame_done), 16'h1);
      end
   endtask

   initial begin
      bus.load     = 1'b0;
      bus.data_in  = '0;
      bus.dp_in    = '0;
      bus.blank_lz = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst seg", 16'(bus.seg_n), 16'h7F);
      chk("rst dp", 16'(bus.dp_n), 16'h1);
      chk("rst an", 16'(bus.an_n), 16'hF);
      chk("rst fd", 16'(bus.frame_done), 16'h0);
      rst = 1'b0;

      // Cleared data shows 0 on all digits; load 1234 mid-frame is deferred
      run_frame("f0", {4{7'b1000000}}, 4'b1111, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0, 16);
      run_frame("f1", {4{7'b1000000}}, 4'b1111, 5, 16'h1234, 4'b0101, -1, 16'h0, 4'h0, 16);
      // 1234: digits 0..3 = 4,3,2,1; queue 0070 with dp on digit 2
      run_frame("f2", {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 4'b1010,
                8, 16'h0070, 4'b0100, -1, 16'h0, 4'h0, 16);
      // Leading-zero blanking on, blanked digit 2 keeps its dp
      bus.blank_lz = 1'b1;
      run_frame("f3", {7'b1111111, 7'b1111111, 7'b1111000, 7'b1000000}, 4'b1011,
                -1, 16'h0, 4'h0, -1, 16'h0, 4'h0, 16);
      bus.blank_lz = 1'b0;
      run_frame("f4", {7'b1000000, 7'b1000000, 7'b1111000, 7'b1000000}, 4'b1011,
                3, 16'hA5F9, 4'b1000, -1, 16'h0, 4'h0, 16);
      // A5F9: non-decimal nibbles blank; two loads, last one wins
      run_frame("f5", {7'b1111111, 7'b0010010, 7'b1111111, 7'b0010000}, 4'b0111,
                2, 16'h1111, 4'h0, 10, 16'h2222, 4'h0, 16);
      // 2222 shown; 9999 pending then 3333 on the frame-boundary tick
      run_frame("f6", {4{7'b0100100}}, 4'b1111, 6, 16'h9999, 4'h0, 15, 16'h3333, 4'h0, 16);
      run_frame("f7", {4{7'b0110000}}, 4'b1111, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0, 16);
      run_frame("f8", {4{7'b0110000}}, 4'b1111, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0, 16);

      // Reset mid-slot with a pending load
      run_frame("f9", {4{7'b0110000}}, 4'b1111, 4, 16'h5555, 4'hF, -1, 16'h0, 4'h0, 7);
      #2 rst = 1'b1;
      #1;
      chk("mid rst seg", 16'(bus.seg_n), 16'h7F);
      chk("mid rst dp", 16'(bus.dp_n), 16'h1);
      chk("mid rst an", 16'(bus.an_n), 16'hF);
      chk("mid rst fd", 16'(bus.frame_done), 16'h0);
      @(negedge clk);
      rst = 1'b0;
      run_frame("f10", {4{7'b1000000}}, 4'b1111, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0, 16);
      run_frame("f11", {4{7'b1000000}}, 4'b1111, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0, 16);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50000, clocks per digit slot (minimum 4).
REQ-002 SHALL have parameter DEAD_CYC, default 2, blanking clocks at the start of each slot (less than CLK_DIV).
REQ-003 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port load  input  1  one-cycle strobe capturing data_in and dp_in.
REQ-006 SHALL have port data_in  input  16  four BCD nibbles, [3:0] = digit 0 (rightmost).
REQ-007 SHALL have port dp_in  input  4  decimal point per digit, 1 = lit.
REQ-008 SHALL have port blank_lz  input  1  leading-zero suppression enable.
REQ-009 SHALL have port seg_n  output  7  segments {g,f,e,d,c,b,a}, active low.
REQ-010 SHALL have port dp_n  output  1  decimal point, active low.
REQ-011 SHALL have port an_n  output  4  digit enables, active low, bit i = digit i.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse at end of each 4-digit frame.

Function
REQ-013 Prescaler SHALL count 0..CLK_DIV-1 and wrap to 0; tick asserted when count = CLK_DIV-1.
REQ-014 Digit index SHALL advance 0->1->2->3->0 on each tick.
REQ-015 frame_done SHALL pulse the cycle after a tick taken with index = 3.
REQ-016 Display data SHALL be held in an active register and a pending register with pending_valid flag.
REQ-017 load SHALL write pending and set pending_valid; a later load before transfer overwrites (last wins).
REQ-018 On a tick with index = 3, pending SHALL copy to active and pending_valid clear; no mid-frame change.
REQ-019 load in the same cycle as the index-3 tick SHALL bypass pending: data_in goes directly to active, pending_valid cleared.
REQ-020 Outputs SHALL be registered, reflecting the new index one clock after the tick.
REQ-021 While prescaler count < DEAD_CYC, an_n SHALL be 4'b1111; otherwise exactly one an_n bit (current index) low.
REQ-022 Decode SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-023 Nibble values 10-15 SHALL yield seg_n = 1111111 (blank); no latched or undefined output.
REQ-024 With blank_lz = 1, a zero digit SHALL blank when it and every more-significant digit are zero; digit 0 never blanked.
REQ-025 Blanked digits SHALL still honour dp_in; dp_n = ~dp bit of current digit.
REQ-026 blank_lz SHALL be sampled live each slot (not captured by load).

Reset
REQ-027 rst asserted SHALL immediately force prescaler 0, index 0, active 0, pending 0, pending_valid 0.
REQ-028 During and after reset SHALL hold seg_n = 1111111, dp_n = 1, an_n = 1111, frame_done = 0 until first post-reset slot output.
REQ-029 Reset mid-frame SHALL discard pending data; scanning restarts at digit 0.

Structure
REQ-030 Shared package seg7_pkg SHALL hold the ten segment constants, SEG_BLANK = 7'h7F, and NUM_DIGITS = 4.
REQ-031 Decode SHALL be a combinational sub-module bcd_seg7_dec (4-bit in, 7-bit active-low out, default blank).
REQ-032 Controller SHALL be one prescaler, one index counter, data registers and output registers; no other sub-modules.

Verification (CLK_DIV = 4, DEAD_CYC = 1)
REQ-033 Reset release, no load -> digits 0..3 show 1000000 in turn; an_n sequence 1110,1101,1011,0111; frame_done every 16 clocks.
REQ-034 load data_in = 16'h1234 mid-frame -> old data to frame end, next frame digit 0..3 = 0011001,0110000,0100100,1111001.
REQ-035 data_in = 16'h0070, blank_lz = 1 -> digits 3,2 blank, digit 1 = 1111000, digit 0 = 1000000; blank_lz = 0 -> digits 3,2 = 1000000.
REQ-036 data_in = 16'hA5F9 -> digits 3,1 = 1111111, digit 2 = 0010010, digit 0 = 0010000.
REQ-037 Two loads (16'h1111 then 16'h2222) in one frame -> next frame shows only 2222; load on index-3 tick -> value shown next frame.
REQ-038 rst pulsed mid-slot with pending load -> outputs blank immediately, restart at digit 0 showing 0000, pending load lost.
